// File: rtl/alu_pkg.sv
// Shared constants and decoded-control payload for the ALU decode stage.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OPC_W    = 7;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SLT  = 4'b0100;
  localparam logic [SEL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'b1000;
  localparam logic [SEL_W-1:0] ALU_SRL  = 4'b1010;
  localparam logic [SEL_W-1:0] ALU_SRA  = 4'b1011;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'b1100;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'b1110;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // Width-independent part of the decoded bundle; imm and pc travel alongside.
  typedef struct packed {
    logic [SEL_W-1:0] alu_select;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             use_imm;
    logic             use_pc;
    logic             reg_write;
    logic             illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational decoder: instruction word -> ALU control bundle and immediate.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [ILEN-1:0] instr,
  output dec_ctrl_t       ctrl_c,
  output logic [XLEN-1:0] imm_c
);

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             legal;

  always_comb begin
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    ctrl_c = '0;
    imm_c  = '0;
    legal  = 1'b0;
    ctrl_c.rd  = instr[11:7];
    ctrl_c.rs1 = instr[19:15];
    ctrl_c.rs2 = instr[24:20];

    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        ctrl_c.alu_select = {funct3, funct7[5]};
        ctrl_c.reg_write  = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_c.rs2       = '0;
        ctrl_c.use_imm   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        // Only shifts carry a funct7; ADDI with a negative immediate must stay ADD.
        case (funct3)
          3'b001: begin
            legal             = (funct7 == 7'b0000000);
            imm_c             = XLEN'(instr[24:20]);
            ctrl_c.alu_select = {funct3, 1'b0};
          end
          3'b101: begin
            legal             = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            imm_c             = XLEN'(instr[24:20]);
            ctrl_c.alu_select = {funct3, instr[30]};
          end
          default: begin
            legal             = 1'b1;
            imm_c             = XLEN'($signed(instr[31:20]));
            ctrl_c.alu_select = {funct3, 1'b0};
          end
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        legal             = 1'b1;
        ctrl_c.rs1        = '0;
        ctrl_c.rs2        = '0;
        ctrl_c.alu_select = ALU_ADD;
        ctrl_c.use_imm    = 1'b1;
        ctrl_c.use_pc     = (opcode == OPC_AUIPC);
        ctrl_c.reg_write  = 1'b1;
        imm_c             = XLEN'($signed({instr[31:12], 12'b0}));
      end
      default: legal = 1'b0;
    endcase

    // Undecodable words still flow downstream, but as an inert ADD with no writeback.
    if (!legal) begin
      ctrl_c.alu_select = ALU_ADD;
      ctrl_c.use_imm    = 1'b0;
      ctrl_c.use_pc     = 1'b0;
      ctrl_c.reg_write  = 1'b0;
      ctrl_c.rs1        = instr[19:15];
      ctrl_c.rs2        = instr[24:20];
      imm_c             = '0;
    end
    ctrl_c.illegal = !legal;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode pipeline stage between fetch and execute: output register plus one-entry skid buffer.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_select,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic            out_reg_write,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  dec_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  logic            out_valid_q, out_valid_d;
  dec_ctrl_t       out_ctrl_q,  out_ctrl_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  logic [XLEN-1:0] out_pc_q,    out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  dec_ctrl_t       skid_ctrl_q,  skid_ctrl_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;

  logic accept;
  logic out_load;

  alu_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr  (in_instr),
    .ctrl_c (dec_ctrl),
    .imm_c  (dec_imm)
  );

  // Output slot refills from the skid entry first so ordering stays FIFO.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_imm_d    = out_imm_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;
    accept       = in_valid && !skid_valid_q;
    out_load     = !out_valid_q || out_ready;

    if (out_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_imm_d    = skid_imm_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_ctrl_d = dec_ctrl;
          out_imm_d  = dec_imm;
          out_pc_d   = in_pc;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = dec_ctrl;
      skid_imm_d   = dec_imm;
      skid_pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_ctrl_q   <= '0;
      out_imm_q    <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ctrl_q   <= out_ctrl_d;
      out_imm_q    <= out_imm_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_ready       = !skid_valid_q;
  assign out_valid      = out_valid_q;
  assign out_alu_select = out_ctrl_q.alu_select;
  assign out_rs1        = out_ctrl_q.rs1;
  assign out_rs2        = out_ctrl_q.rs2;
  assign out_rd         = out_ctrl_q.rd;
  assign out_imm        = out_imm_q;
  assign out_use_imm    = out_ctrl_q.use_imm;
  assign out_use_pc     = out_ctrl_q.use_pc;
  assign out_reg_write  = out_ctrl_q.reg_write;
  assign out_illegal    = out_ctrl_q.illegal;
  assign out_pc         = out_pc_q;

endmodule
